// File: rtl/cpu_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM state encoding and default sizing.
package cpu_ctrl_pkg;

  localparam int unsigned DEF_REG_ADDR_W = 5;
  localparam int unsigned DEF_MAX_WAIT   = 255;
  localparam int unsigned WAIT_CNT_W     = 16;
  localparam int unsigned PERF_CNT_W     = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ISTALL = 2'd1,
    DSTALL = 2'd2,
    FAULT  = 2'd3
  } hz_state_e;

  function automatic logic is_wait(input hz_state_e s);
    return (s == ISTALL) || (s == DSTALL);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Consecutive memory-wait counter; flags the cycle on which one more wait would exceed MAX_WAIT.
module wait_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clock,
  input  logic reset,
  input  logic waiting,
  output logic expired
);

  localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(MAX_WAIT - 1);

  logic [WAIT_CNT_W-1:0] wait_cnt;

  assign expired = waiting && (wait_cnt == LAST_CNT);

  // Expiry diverts the FSM to FAULT, so the count is not advanced past the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (waiting && !expired) begin
      wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, fetch/data memory stalls, branch flush, wait timeout.
// Optional stall_cycles performance counter enabled by macro HAZARD_PERF_COUNT_EN.
module hazard_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_Rt,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rt,
  input  logic                  branch_taken,
  input  logic                  imem_ready,
  input  logic                  dmem_busy,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Bubble,
  output logic                  Pipe_Hold,
`ifdef HAZARD_PERF_COUNT_EN
  output logic [PERF_CNT_W-1:0] stall_cycles,
`endif
  output logic                  fault
);

  hz_state_e state;
  hz_state_e state_next;
  hz_state_e rule_next;
  logic      load_use;
  logic      branch_accept;
  logic      flush_pending;
  logic      wait_expired;

  assign load_use = ID_EX_MemRead && (ID_EX_Rt != '0) &&
                    ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

  // A branch seen during a load-use or data stall is re-presented by ID later.
  assign branch_accept = branch_taken && !dmem_busy && !load_use;

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .waiting ((state != FAULT) && is_wait(rule_next)),
    .expired (wait_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    rule_next  = RUN;
    state_next = state;
    if (dmem_busy) begin
      rule_next = DSTALL;
    end else if (load_use) begin
      rule_next = RUN;
    end else if (!imem_ready) begin
      rule_next = ISTALL;
    end
    if (state == FAULT) begin
      state_next = FAULT;
    end else if (wait_expired) begin
      state_next = FAULT;
    end else begin
      state_next = rule_next;
    end
  end

  always_comb begin
    PC_Write     = 1'b0;
    IF_ID_Write  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    Pipe_Hold    = 1'b0;
    fault        = 1'b0;
    if (!reset) begin
      if (state == FAULT) begin
        ID_EX_Bubble = 1'b1;
        Pipe_Hold    = 1'b1;
        fault        = 1'b1;
      end else if (dmem_busy) begin
        Pipe_Hold = 1'b1;
      end else if (load_use || !imem_ready) begin
        ID_EX_Bubble = 1'b1;
      end else begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = branch_accept || flush_pending;
      end
    end
  end

  // Remembers a taken branch until the wrong-path fetch actually lands in IF/ID.
  always_ff @(posedge clock) begin
    if (reset) begin
      flush_pending <= 1'b0;
    end else if (IF_ID_Write) begin
      flush_pending <= 1'b0;
    end else if (branch_accept) begin
      flush_pending <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_COUNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!PC_Write && (state != FAULT) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + PERF_CNT_W'(1);
    end
  end

  assign stall_cycles = reset ? '0 : stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed vector bench for hazard_controller (MAX_WAIT=4); stall_cycles checked when HAZARD_PERF_COUNT_EN is defined.
module tb_hazard_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ID_EX_MemRead = 1'b0;
  logic [4:0] ID_EX_Rt = '0;
  logic [4:0] IF_ID_Rs = '0;
  logic [4:0] IF_ID_Rt = '0;
  logic       branch_taken = 1'b0;
  logic       imem_ready = 1'b1;
  logic       dmem_busy = 1'b0;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Hold, fault;
`ifdef HAZARD_PERF_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  hazard_controller #(.REG_ADDR_W(5), .MAX_WAIT(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_EX_Rt      (ID_EX_Rt),
    .IF_ID_Rs      (IF_ID_Rs),
    .IF_ID_Rt      (IF_ID_Rt),
    .branch_taken  (branch_taken),
    .imem_ready    (imem_ready),
    .dmem_busy     (dmem_busy),
    .PC_Write      (PC_Write),
    .IF_ID_Write   (IF_ID_Write),
    .IF_ID_Flush   (IF_ID_Flush),
    .ID_EX_Bubble  (ID_EX_Bubble),
    .Pipe_Hold     (Pipe_Hold),
`ifdef HAZARD_PERF_COUNT_EN
    .stall_cycles  (stall_cycles),
`endif
    .fault         (fault)
  );

  always #5 clock = ~clock;

  // Expected output word order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Hold, fault}
  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] N  = 6'b110000;
  localparam logic [5:0] NF = 6'b111000;
  localparam logic [5:0] B  = 6'b000100;
  localparam logic [5:0] H  = 6'b000010;
  localparam logic [5:0] F  = 6'b000111;

  typedef struct {
    string      name;
    logic       rst;
    logic       mr;
    logic [4:0] exrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       irdy;
    logic       dbusy;
    logic [5:0] exp;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input string name, input logic rst, input logic mr,
                              input logic [4:0] exrt, input logic [4:0] rs, input logic [4:0] rt,
                              input logic br, input logic irdy, input logic dbusy,
                              input logic [5:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.mr = mr; v.exrt = exrt; v.rs = rs; v.rt = rt;
    v.br = br; v.irdy = irdy; v.dbusy = dbusy; v.exp = exp;
    return v;
  endfunction

  // One cycle: drive on the falling edge, sample 1ns later, well before the next rising edge.
  task automatic apply(input vec_t v);
    logic [5:0] got;
    @(negedge clock);
    reset = v.rst; ID_EX_MemRead = v.mr; ID_EX_Rt = v.exrt; IF_ID_Rs = v.rs; IF_ID_Rt = v.rt;
    branch_taken = v.br; imem_ready = v.irdy; dmem_busy = v.dbusy;
    #1;
    got = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Hold, fault};
    n_vec++;
    if (got !== v.exp) begin
      n_err++;
      $display("FAIL %s: pcw/ifw/flush/bubble/hold/fault got %b expected %b", v.name, got, v.exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    //               name               rst mr exrt rs  rt br irdy dbusy exp
    tbl.push_back(mk("reset_outputs",     1, 1, 8,  8,  0, 1, 0,   1,   Z));
    tbl.push_back(mk("normal",            0, 0, 0,  1,  2, 0, 1,   0,   N));
    tbl.push_back(mk("load_use_rs",       0, 1, 8,  8,  3, 0, 1,   0,   B));
    tbl.push_back(mk("after_load_use",    0, 0, 0,  8,  3, 0, 1,   0,   N));
    tbl.push_back(mk("load_use_rt",       0, 1, 9,  1,  9, 0, 1,   0,   B));
    tbl.push_back(mk("load_rt_zero",      0, 1, 0,  0,  0, 0, 1,   0,   N));
    tbl.push_back(mk("load_no_match",     0, 1, 8,  7,  6, 0, 1,   0,   N));
    tbl.push_back(mk("branch_flush",      0, 0, 0,  0,  0, 1, 1,   0,   NF));
    tbl.push_back(mk("flush_one_cycle",   0, 0, 0,  0,  0, 0, 1,   0,   N));
    tbl.push_back(mk("branch_vs_loaduse", 0, 1, 8,  8,  0, 1, 1,   0,   B));
    tbl.push_back(mk("branch_ignored_lu", 0, 0, 0,  0,  0, 0, 1,   0,   N));
    tbl.push_back(mk("branch_vs_dbusy",   0, 0, 0,  0,  0, 1, 1,   1,   H));
    tbl.push_back(mk("branch_ignored_db", 0, 0, 0,  0,  0, 0, 1,   0,   N));
    tbl.push_back(mk("dbusy_over_imem",   0, 0, 0,  0,  0, 0, 0,   1,   H));
    tbl.push_back(mk("loaduse_over_imem", 0, 1, 5,  0,  5, 0, 0,   0,   B));
    tbl.push_back(mk("imem_wait",         0, 0, 0,  0,  0, 0, 0,   0,   B));
    tbl.push_back(mk("imem_done",         0, 0, 0,  0,  0, 0, 1,   0,   N));

    foreach (tbl[i]) apply(tbl[i]);

    // Branch resolved while the fetch is still outstanding.
    apply(mk("br_fetch_wait0",  0, 0, 0, 0, 0, 1, 0, 0, B));
    apply(mk("br_fetch_wait1",  0, 0, 0, 0, 0, 0, 0, 0, B));
    apply(mk("br_fetch_land",   0, 0, 0, 0, 0, 0, 1, 0, NF));
    apply(mk("br_fetch_after",  0, 0, 0, 0, 0, 0, 1, 0, N));

    // Data wait overlapping a load-use hazard, then a single bubble.
    for (int i = 0; i < 3; i++) apply(mk($sformatf("dwait_lu_%0d", i), 0, 1, 8, 8, 0, 0, 1, 1, H));
    apply(mk("dwait_bubble",    0, 1, 8, 8, 0, 0, 1, 0, B));
    apply(mk("dwait_resume",    0, 0, 0, 8, 0, 0, 1, 0, N));

    // Fetch timeout with MAX_WAIT=4: four wait cycles, fault from the fifth.
    for (int i = 1; i <= 4; i++) apply(mk($sformatf("tmo_wait_%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, B));
    apply(mk("tmo_fault",       0, 0, 0, 0, 0, 0, 0, 0, F));
    apply(mk("fault_sticky",    0, 0, 0, 0, 0, 1, 1, 0, F));
    apply(mk("fault_sticky_lu", 0, 1, 8, 8, 0, 0, 1, 1, F));
    apply(mk("fault_in_reset",  1, 0, 0, 0, 0, 0, 1, 0, Z));
    apply(mk("fault_cleared",   0, 0, 0, 0, 0, 0, 1, 0, N));

    // Reset in the middle of a data stall clears everything.
    apply(mk("mid_stall",       0, 0, 0, 0, 0, 1, 1, 1, H));
    apply(mk("mid_stall_reset", 1, 0, 0, 0, 0, 0, 1, 1, Z));
    apply(mk("post_reset",      0, 0, 0, 0, 0, 0, 1, 0, N));

`ifdef HAZARD_PERF_COUNT_EN
    apply(mk("perf_reset",      1, 0, 0, 0, 0, 0, 1, 0, Z));
    apply(mk("perf_idle",       0, 0, 0, 0, 0, 0, 1, 0, N));
    check32("stall_cycles_zero", stall_cycles, 32'd0);
    for (int i = 0; i < 10; i++) apply(mk($sformatf("perf_lu_%0d", i), 0, 1, 3, 3, 0, 0, 1, 0, B));
    apply(mk("perf_after",      0, 0, 0, 0, 0, 0, 1, 0, N));
    check32("stall_cycles_ten", stall_cycles, 32'd10);
    apply(mk("perf_reset2",     1, 0, 0, 0, 0, 0, 1, 0, Z));
    apply(mk("perf_idle2",      0, 0, 0, 0, 0, 0, 1, 0, N));
    check32("stall_cycles_cleared", stall_cycles, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
